operand_regfile: RTL and testbench

Parameterised register file that supplies the two operands feeding the datapath's 2:1 operand-select multiplexer (`outA` → mux `inA`, `outB` → mux `inB`). It holds 2^`a` registers of `n` bits, with one synchronous write port and two registered read ports. Register 0 is hardwired to zero. An optional write-to-read bypass removes the one-cycle read-after-write hazard.

---
 rtl/operand_regfile.sv | 42 ++++
 tb/tb_operand_regfile.sv | 131 +++++++++++++
 2 files changed

// File: rtl/operand_regfile.sv
// operand_regfile: 2^a x n register file, one write port, two registered read ports, reg 0 hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto a colliding read port.
module operand_regfile #(
  parameter int n = 5,
  parameter int a = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [a-1:0] waddr,
  input  logic [n-1:0] wdata,
  input  logic         re,
  input  logic [a-1:0] raddrA,
  input  logic [a-1:0] raddrB,
  output logic [n-1:0] outA,
  output logic [n-1:0] outB
);
`ifdef REGFILE_BYPASS_EN
  localparam bit byp = 1'b1;
`else
  localparam bit byp = 1'b0;
`endif
  logic [n-1:0] mem [0:(1<<a)-1];
  logic [n-1:0] rda, rdb;
  always_comb begin
    rda = raddrA == '0 ? '0 : (byp && we && waddr == raddrA) ? wdata : mem[raddrA];
    rdb = raddrB == '0 ? '0 : (byp && we && waddr == raddrB) ? wdata : mem[raddrB];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < (1 << a); i++) mem[i] <= '0;
      outA <= '0;
      outB <= '0;
    end else begin
      if (we && waddr != '0) mem[waddr] <= wdata;
      if (re) begin
        outA <= rda;
        outB <= rdb;
      end
    end
  end
endmodule

// File: tb/tb_operand_regfile.sv
// tb_operand_regfile: randomized and directed checks of operand_regfile against an array-based reference model.
module tb_operand_regfile;
  localparam int N = 5;
  localparam int A = 3;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 0;
  logic rst = 1;
  logic we = 0, re = 0;
  logic [A-1:0] waddr = 0, raddrA = 0, raddrB = 0;
  logic [N-1:0] wdata = 0;
  logic [N-1:0] outA, outB;
  logic w8_we = 0, w8_re = 0;
  logic [1:0] w8_waddr = 0, w8_raddrA = 0, w8_raddrB = 0;
  logic [7:0] w8_wdata = 0;
  logic [7:0] w8_outA, w8_outB;
  int vectors = 0, errors = 0;
  logic [N-1:0] m [8];
  logic [N-1:0] ea = 0, eb = 0;

  always #5 clk = ~clk;

  operand_regfile #(.n(N), .a(A)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .re(re),
    .raddrA(raddrA), .raddrB(raddrB), .outA(outA), .outB(outB)
  );

  operand_regfile #(.n(8), .a(2)) dut8 (
    .clk(clk), .rst(rst), .we(w8_we), .waddr(w8_waddr), .wdata(w8_wdata), .re(w8_re),
    .raddrA(w8_raddrA), .raddrB(w8_raddrB), .outA(w8_outA), .outB(w8_outB)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] rd(input logic [A-1:0] ad);
    if (ad == 0) return '0;
    if (BYP && we && ad == waddr) return wdata;
    return m[ad];
  endfunction

  task automatic tick(input string tag);
    if (rst) begin
      foreach (m[i]) m[i] = '0;
      ea = '0;
      eb = '0;
    end else begin
      if (re) begin
        ea = rd(raddrA);
        eb = rd(raddrB);
      end
      if (we && waddr != 0) m[waddr] = wdata;
    end
    @(posedge clk);
    #1;
    check({tag, ".outA"}, outA, ea);
    check({tag, ".outB"}, outB, eb);
  endtask

  task automatic wr(input logic [A-1:0] ad, input logic [N-1:0] d, input string tag);
    we = 1; waddr = ad; wdata = d; re = 0;
    tick(tag);
    we = 0;
  endtask

  task automatic rdp(input logic [A-1:0] x, input logic [A-1:0] y, input string tag);
    re = 1; raddrA = x; raddrB = y;
    tick(tag);
  endtask

  initial begin
    tick("reset0");
    rst = 0;
    wr(3, 7, "preload");
    rst = 1; we = 1; waddr = 3; wdata = 9; re = 1; raddrA = 3; raddrB = 3;
    tick("reset_write");
    check("reset_outA_zero", outA, 0);
    rst = 0; we = 0;
    rdp(3, 3, "post_reset_read");
    check("post_reset_reg3", outA, 0);
    wr(1, 1, "w1");
    wr(2, 2, "w2");
    rdp(1, 2, "read12");
    check("read12_direct", {outA, outB}, {5'd1, 5'd2});
    rdp(2, 1, "read21");
    wr(0, 31, "w0");
    rdp(0, 0, "read0");
    check("reg0_zero", {outA, outB}, 0);
    wr(4, 3, "w4");
    we = 1; waddr = 4; wdata = 4; re = 1; raddrA = 4; raddrB = 1;
    tick("collide");
    check("collide_direct", outA, BYP ? 4 : 3);
    we = 0;
    rdp(4, 4, "reread4");
    check("reread4_direct", outA, 4);
    rdp(1, 1, "hold_pre");
    re = 0; we = 1; waddr = 1; wdata = 17; raddrA = 2;
    tick("hold");
    check("hold_direct", outA, 1);
    we = 0;
    rdp(1, 1, "hold_release");
    check("hold_release_direct", outA, 17);
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      we = $urandom_range(0, 1);
      re = ($urandom_range(0, 3) != 0);
      waddr = A'($urandom);
      wdata = N'($urandom);
      raddrA = ($urandom_range(0, 3) == 0) ? waddr : A'($urandom);
      raddrB = ($urandom_range(0, 3) == 0) ? waddr : A'($urandom);
      tick("rand");
    end
    rst = 0; we = 0; re = 0;
    w8_we = 1; w8_waddr = 3; w8_wdata = 8'hA5;
    @(posedge clk); #1;
    w8_we = 0; w8_re = 1; w8_raddrA = 3; w8_raddrB = 3;
    @(posedge clk); #1;
    check("width8.outA", w8_outA, 8'hA5);
    check("width8.outB", w8_outB, 8'hA5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
